// File: rtl/l2_msg2_receiver.sv
// L2 msg2 response receiver: buffers beats in a small FIFO, classifies the head
// entry, and polices the L2 hold rule while the receiver applies backpressure.
module l2_msg2_receiver #(
  parameter int unsigned DEPTH           = 2,
  parameter logic [7:0]  TYPE_DATA_ACK   = 8'h04,
  parameter logic [7:0]  TYPE_NODATA_ACK = 8'h05,
  parameter logic [7:0]  TYPE_INV_FWD    = 8'h06,
  parameter int unsigned STALL_MAX       = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        msg2_valid,
  input  logic [7:0]  msg2_type,
  input  logic [25:0] msg2_tag,
  input  logic [63:0] msg2_data,
  output logic        msg2_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_type,
  output logic [25:0] out_tag,
  output logic [63:0] out_data,
  output logic        out_is_data_ack,
  output logic        out_is_nodata_ack,
  output logic        out_is_inv_fwd,
  output logic        out_unknown,
  output logic [7:0]  stall_cnt,
  output logic        proto_err,
  output logic [1:0]  err_code,
  output logic [15:0] rx_count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  localparam logic [7:0]  SMAX = 8'(STALL_MAX);

  logic [7:0]  type_mem_q [DEPTH];
  logic [25:0] tag_mem_q  [DEPTH];
  logic [63:0] data_mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q, count_d;
  logic [15:0]   rx_count_q;
  logic [7:0]    stall_cnt_q, stall_cnt_d;
  logic          prev_stall_q;
  logic [97:0]   snap_q;
  logic          proto_err_q, proto_err_d;
  logic [1:0]    err_code_q, err_code_d;

  logic push, pop, stall_now, viol_drop, viol_chg;
  logic is_data, is_nodata, is_inv;

  assign msg2_ready = (count_q != FULL);
  assign out_valid  = (count_q != '0);
  assign push       = msg2_valid && msg2_ready;
  assign pop        = out_valid && out_ready;
  assign stall_now  = msg2_valid && !msg2_ready;

  // The snapshot is compared whole; a drop (01) outranks a payload change (10).
  assign viol_drop = prev_stall_q && !msg2_valid;
  assign viol_chg  = prev_stall_q && msg2_valid &&
                     ({msg2_type, msg2_tag, msg2_data} != snap_q);

  always_comb begin
    count_d     = count_q;
    stall_cnt_d = '0;
    proto_err_d = proto_err_q;
    err_code_d  = err_code_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (stall_now) begin
      stall_cnt_d = (stall_cnt_q == SMAX) ? stall_cnt_q : stall_cnt_q + 1'b1;
    end
    if (viol_drop || viol_chg) begin
      proto_err_d = 1'b1;
      if (!proto_err_q) begin
        err_code_d = viol_drop ? 2'b01 : 2'b10;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        type_mem_q[i] <= '0;
        tag_mem_q[i]  <= '0;
        data_mem_q[i] <= '0;
      end
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      rx_count_q   <= '0;
      stall_cnt_q  <= '0;
      prev_stall_q <= 1'b0;
      snap_q       <= '0;
      proto_err_q  <= 1'b0;
      err_code_q   <= '0;
    end else begin
      if (push) begin
        type_mem_q[wr_ptr_q] <= msg2_type;
        tag_mem_q[wr_ptr_q]  <= msg2_tag;
        data_mem_q[wr_ptr_q] <= msg2_data;
        wr_ptr_q             <= wr_ptr_q + 1'b1;
        rx_count_q           <= rx_count_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q      <= count_d;
      stall_cnt_q  <= stall_cnt_d;
      prev_stall_q <= stall_now;
      snap_q       <= {msg2_type, msg2_tag, msg2_data};
      proto_err_q  <= proto_err_d;
      err_code_q   <= err_code_d;
    end
  end

  assign out_type = type_mem_q[rd_ptr_q];
  assign out_tag  = tag_mem_q[rd_ptr_q];
  assign out_data = data_mem_q[rd_ptr_q];

  assign is_data   = (out_type == TYPE_DATA_ACK);
  assign is_nodata = (out_type == TYPE_NODATA_ACK);
  assign is_inv    = (out_type == TYPE_INV_FWD);

  assign out_is_data_ack   = out_valid && is_data;
  assign out_is_nodata_ack = out_valid && is_nodata;
  assign out_is_inv_fwd    = out_valid && is_inv;
  assign out_unknown       = out_valid && !(is_data || is_nodata || is_inv);

  assign stall_cnt = stall_cnt_q;
  assign proto_err = proto_err_q;
  assign err_code  = err_code_q;
  assign rx_count  = rx_count_q;

endmodule

// File: tb/tb_l2_msg2_receiver.sv
// Directed and randomized bench for l2_msg2_receiver against a queue-based model.
module tb_l2_msg2_receiver;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        v = 1'b0;
  logic [7:0]  ty = '0;
  logic [25:0] tg = '0;
  logic [63:0] dt = '0;
  logic        ordy = 1'b0;

  logic        msg2_ready, out_valid;
  logic [7:0]  out_type;
  logic [25:0] out_tag;
  logic [63:0] out_data;
  logic        f_data, f_nodata, f_inv, f_unk;
  logic [7:0]  stall_cnt;
  logic        proto_err;
  logic [1:0]  err_code;
  logic [15:0] rx_count;

  l2_msg2_receiver #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .msg2_valid(v), .msg2_type(ty), .msg2_tag(tg), .msg2_data(dt),
    .msg2_ready(msg2_ready),
    .out_valid(out_valid), .out_ready(ordy),
    .out_type(out_type), .out_tag(out_tag), .out_data(out_data),
    .out_is_data_ack(f_data), .out_is_nodata_ack(f_nodata),
    .out_is_inv_fwd(f_inv), .out_unknown(f_unk),
    .stall_cnt(stall_cnt), .proto_err(proto_err), .err_code(err_code),
    .rx_count(rx_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  t;
    logic [25:0] g;
    logic [63:0] d;
  } beat_t;

  beat_t       q[$];
  logic [15:0] m_rx;
  int          m_accepted;
  int          m_stall;
  bit          m_prev_stall;
  beat_t       m_snap;
  bit          m_perr;
  logic [1:0]  m_ecode;

  int passed = 0;
  int total  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [3:0] flags_exp();
    if (q.size() == 0) return 4'b0000;
    case (q[0].t)
      8'h04:   return 4'b1000;
      8'h05:   return 4'b0100;
      8'h06:   return 4'b0010;
      default: return 4'b0001;
    endcase
  endfunction

  task automatic model_clear();
    q.delete();
    m_rx = '0; m_accepted = 0; m_stall = 0; m_prev_stall = 0;
    m_snap = '{8'h0, 26'h0, 64'h0};
    m_perr = 0; m_ecode = 2'b00;
  endtask

  // One clock: compare outputs with the model, take an edge, then advance the model.
  task automatic step();
    beat_t cur;
    bit mready, push, pop, stall_now, drop, chg;
    cur = '{ty, tg, dt};
    mready = (q.size() < DEPTH);
    push = v && mready;
    pop  = (q.size() != 0) && ordy;
    check("msg2_ready", 64'(msg2_ready), 64'(mready));
    check("out_valid", 64'(out_valid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      check("out_type", 64'(out_type), 64'(q[0].t));
      check("out_tag", 64'(out_tag), 64'(q[0].g));
      check("out_data", out_data, q[0].d);
    end
    check("flags", 64'({f_data, f_nodata, f_inv, f_unk}), 64'(flags_exp()));
    check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
    check("rx_count", 64'(rx_count), 64'(m_rx));
    check("proto_err", 64'(proto_err), 64'(m_perr));
    check("err_code", 64'(err_code), 64'(m_ecode));
    stall_now = v && !mready;
    drop = m_prev_stall && !v;
    chg  = m_prev_stall && v && (cur != m_snap);
    @(posedge clk); #1;
    if (pop) void'(q.pop_front());
    if (push) begin q.push_back(cur); m_rx++; m_accepted++; end
    if ((drop || chg) && !m_perr) m_ecode = drop ? 2'b01 : 2'b10;
    if (drop || chg) m_perr = 1;
    m_stall = stall_now ? ((m_stall >= 255) ? 255 : m_stall + 1) : 0;
    m_prev_stall = stall_now;
    m_snap = cur;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; v = 1'b0; ordy = 1'b0;
    #3;
    model_clear();
    check("rst_ready", 64'(msg2_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_heads", {out_type, out_tag[23:0], out_data[31:0]}, 64'd0);
    check("rst_flags", 64'({f_data, f_nodata, f_inv, f_unk}), 64'd0);
    check("rst_misc", 64'({stall_cnt, proto_err, err_code, rx_count}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drive(input logic [7:0] t, input logic [25:0] g, input logic [63:0] d);
    v = 1'b1; ty = t; tg = g; dt = d;
  endtask

  initial begin
    model_clear();
    do_reset();

    // single data-ack beat, one-cycle latency, then pop
    drive(8'h04, 26'h123, 64'hDEAD_BEEF);
    step();
    v = 1'b0;
    check("t1_valid", 64'(out_valid), 64'd1);
    check("t1_dack", 64'(f_data), 64'd1);
    check("t1_data", out_data, 64'hDEAD_BEEF);
    check("t1_rx", 64'(rx_count), 64'd1);
    ordy = 1'b1;
    step();
    check("t1_empty", 64'(out_valid), 64'd0);
    ordy = 1'b0;

    // backpressure: two accepted, third held and counted
    drive(8'h05, 26'h1, 64'h11); step();
    drive(8'h06, 26'h2, 64'h22); step();
    check("t2_full", 64'(msg2_ready), 64'd0);
    drive(8'h04, 26'h3, 64'h33);
    for (int i = 0; i < 3; i++) step();
    check("t2_stall3", 64'(stall_cnt), 64'd3);
    ordy = 1'b1; step(); ordy = 1'b0;
    check("t2_ready_back", 64'(msg2_ready), 64'd1);
    step();
    v = 1'b0;
    check("t2_stall0", 64'(stall_cnt), 64'd0);
    ordy = 1'b1;
    for (int i = 0; i < 3; i++) step();
    ordy = 1'b0;

    // long stall saturates without a protocol error
    drive(8'h04, 26'h7, 64'h70); step();
    drive(8'h04, 26'h8, 64'h80); step();
    drive(8'h05, 26'h9, 64'h90);
    for (int i = 0; i < 300; i++) step();
    check("t3_sat", 64'(stall_cnt), 64'd255);
    check("t3_noerr", 64'(proto_err), 64'd0);
    ordy = 1'b1; step(); step();
    v = 1'b0;
    for (int i = 0; i < 3; i++) step();
    ordy = 1'b0;

    // payload change during stall, later drop keeps first code
    drive(8'h04, 26'h1, 64'h1); step();
    drive(8'h04, 26'h2, 64'h2); step();
    drive(8'h04, 26'h10, 64'h5);
    step(); step();
    tg = 26'h11;
    step();
    check("t4_err", 64'(proto_err), 64'd1);
    check("t4_code", 64'(err_code), 64'd2);
    v = 1'b0;
    step();
    check("t4_code_kept", 64'(err_code), 64'd2);
    do_reset();

    // valid dropped during stall, then unknown type delivered
    drive(8'h05, 26'h4, 64'h4); step();
    drive(8'h06, 26'h5, 64'h5); step();
    drive(8'h04, 26'h6, 64'h6); step();
    v = 1'b0;
    step();
    check("t5_err", 64'(proto_err), 64'd1);
    check("t5_code", 64'(err_code), 64'd1);
    ordy = 1'b1; step(); step(); ordy = 1'b0;
    drive(8'hFF, 26'h3F, 64'hF00D); step();
    v = 1'b0;
    check("t5_unknown", 64'({f_data, f_nodata, f_inv, f_unk}), 64'b0001);
    step();
    do_reset();

    // random traffic that obeys the hold rule
    for (int i = 0; i < 400; i++) begin
      if (!m_prev_stall) begin
        v  = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 3))
          0: ty = 8'h04;
          1: ty = 8'h05;
          2: ty = 8'h06;
          default: ty = 8'($urandom);
        endcase
        tg = 26'($urandom);
        dt = {32'($urandom), 32'($urandom)};
      end
      ordy = 1'($urandom_range(0, 1));
      step();
    end
    check("rand_noerr", 64'(proto_err), 64'd0);
    do_reset();

    // 70000-beat stream through the FIFO, rx_count wraps
    ordy = 1'b1;
    for (int c = 0; c < 71000 && m_accepted < 70000; c++) begin
      if (!m_prev_stall) drive(8'($urandom), 26'($urandom), {32'($urandom), 32'($urandom)});
      step();
    end
    check("t6_rx_wrap", 64'(rx_count), 64'd4464);
    check("t6_streaming", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 64'(out_valid), 64'd0);
    check("t6_rst_ready", 64'(msg2_ready), 64'd1);
    do_reset();
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/l2_msg2_receiver.md
Name: l2_msg2_receiver

Overview:
- Consumer end of the L2 msg2 response channel (L2 -> private cache side).
- Accepts msg2 beats with a valid/ready handshake and buffers them in a small FIFO.
- Presents buffered beats to the local consumer with type classification.
- Checks that the L2 obeys the hold rule: while msg2_valid=1 and msg2_ready=0, valid and all payload fields stay stable. Reports violations and stall duration.

Parameters:
DEPTH, 2, FIFO entries (power of 2, >=2)
TYPE_DATA_ACK, 8'h04, msg2_type value for data acknowledgement
TYPE_NODATA_ACK, 8'h05, msg2_type value for no-data acknowledgement
TYPE_INV_FWD, 8'h06, msg2_type value for invalidation forward
STALL_MAX, 255, saturation value of stall counter (fits 8 bits)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
msg2_valid  in  1  L2 asserts beat present
msg2_type  in  8  message type
msg2_tag  in  26  line tag
msg2_data  in  64  line data
msg2_ready  out  1  receiver can accept a beat this cycle
out_valid  out  1  head entry available
out_ready  in  1  consumer takes head entry
out_type  out  8  head type
out_tag  out  26  head tag
out_data  out  64  head data
out_is_data_ack  out  1  head type == TYPE_DATA_ACK
out_is_nodata_ack  out  1  head type == TYPE_NODATA_ACK
out_is_inv_fwd  out  1  head type == TYPE_INV_FWD
out_unknown  out  1  head type matches none of the above
stall_cnt  out  8  consecutive cycles of valid&&!ready, saturating
proto_err  out  1  sticky hold-rule violation flag
err_code  out  2  first violation: 01 valid dropped, 10 payload changed, 00 none
rx_count  out  16  accepted beats, wraps at 2^16

Behaviour:
- Reset (rst_n=0, asynchronous): FIFO empty, rd/wr pointers 0, count 0.
  - msg2_ready=1, out_valid=0, stall_cnt=0, proto_err=0, err_code=00, rx_count=0.
  - out_type, out_tag, out_data = 0; all classification flags = 0.
- Reset asserted mid-transfer discards all buffered beats. No beat is accepted in the cycle rst_n deasserts unless it is sampled at the following edge.
- msg2_ready = (count != DEPTH). It is derived from registered state only, with no combinational path from out_ready or msg2_valid.
- Push: msg2_valid && msg2_ready at a rising edge.
  - Writes {type,tag,data} to wr_ptr, increments wr_ptr modulo DEPTH.
  - Increments rx_count, wrapping 0xFFFF -> 0x0000.
- Pop: out_valid && out_ready at a rising edge. Increments rd_ptr modulo DEPTH.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- When full, msg2_ready=0, so a same-cycle pop does not allow a push. Ready rises the cycle after the pop.
- out_valid = (count != 0). Head fields come directly from the rd_ptr entry.
- Latency: a beat pushed at edge N appears on out_* after edge N (one cycle) when the FIFO was empty. There is no bypass.
- Classification flags are combinational from out_type, are gated by out_valid, and are mutually exclusive. out_unknown beats are still buffered and delivered.
- Hold checker:
  - Registers prev_stall = msg2_valid && !msg2_ready, plus a snapshot of type/tag/data.
  - If prev_stall=1 and msg2_valid=0 at the next edge, violation 01.
  - Else if prev_stall=1 and any field differs from the snapshot, violation 10.
  - On a violation, proto_err is set sticky until reset, and err_code latches the first violation only.
  - If both violations hold in the same cycle, 01 takes priority.
- stall_cnt:
  - Set to 1 on the first edge where msg2_valid && !msg2_ready.
  - Increments each further consecutive stall edge and saturates at STALL_MAX.
  - Cleared to 0 on any edge where that condition is false.
- Pointer wrap: with DEPTH power of 2, pointers are log2(DEPTH) bits. count is log2(DEPTH)+1 bits.

Test Plan:
- Reset then single beat type 8'h04, tag 26'h123, data 64'hDEAD_BEEF → one cycle later out_valid=1, out_is_data_ack=1, out_data=64'hDEAD_BEEF, rx_count=1; out_ready=1 → out_valid=0 next cycle.
- Hold out_ready=0, send 3 beats → first 2 accepted, msg2_ready=0 after the 2nd, third beat held; stall_cnt counts 1,2,3...; pulse out_ready=1 → ready returns next cycle, third beat accepted, stall_cnt=0.
- Full FIFO with L2 stalling for 300 cycles → stall_cnt saturates at 255, proto_err stays 0.
- During a stall, L2 changes msg2_tag from 26'h10 to 26'h11 → proto_err=1, err_code=10; a later valid drop leaves err_code=10.
- During a stall, L2 drops msg2_valid → proto_err=1, err_code=01; beat type 8'hFF → out_unknown=1, all other flags 0.
- Continuous push+pop for 70000 beats with out_ready=1 → no loss or reorder, rx_count wraps to 70000-65536=4464; assert rst_n low mid-stream → out_valid=0, msg2_ready=1 immediately.
